// File: rtl/dmem_pkg.sv
// Shared opcodes, FSM state type and byte-lane helpers for the pipelined data memory.
// Pure combinational helpers: no latency, no backpressure.
package dmem_pkg;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LBU = 3'b010;
  localparam logic [2:0] MEM_LHU = 3'b011;
  localparam logic [2:0] MEM_LW  = 3'b100;
  localparam logic [2:0] MEM_SB  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;

  typedef enum logic {
    DMEM_INIT = 1'b0,
    DMEM_RUN  = 1'b1
  } dmem_state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return (off != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

  // Big-endian lanes: byte offset 0 lives in word bits [31:24].
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      MEM_LB:  r = {{24{b[7]}}, b};
      MEM_LBU: r = {24'h0, b};
      MEM_LH:  r = {{16{h[15]}}, h};
      MEM_LHU: r = {16'h0, h};
      MEM_LW:  r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Mask bit i enables word bits [8i+7:8i].
  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEM_SB:  return 4'b1000 >> off;
      MEM_SH:  return off[1] ? 4'b0011 : 4'b1100;
      MEM_SW:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] d);
    case (op)
      MEM_SB:  return {4{d[7:0]}};
      MEM_SH:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// Request/response bundle between a load/store stage (master) and dmem_pipe (slave).
// Request is valid/ready; response is an unthrottled valid pulse.
interface dmem_pipe_if;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  memRW;
  logic [31:0] addr;
  logic [31:0] dataW;
  logic        rspValid;
  logic [31:0] dataR;
  logic        fault;
  logic        busy;

  modport master (
    output reqValid, memRW, addr, dataW,
    input  reqReady, rspValid, dataR, fault, busy
  );

  modport slave (
    input  reqValid, memRW, addr, dataW,
    output reqReady, rspValid, dataR, fault, busy
  );
endinterface

// File: rtl/dmem_rsp_pipe.sv
// STAGES-deep delay line for {valid, fault, data}; STAGES=0 is a wire.
// Latency STAGES cycles, no backpressure; reset clears every stage asynchronously.
module dmem_rsp_pipe #(
  parameter int STAGES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vld_i,
  input  logic        flt_i,
  input  logic [31:0] dat_i,
  output logic        vld_o,
  output logic        flt_o,
  output logic [31:0] dat_o
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign vld_o = vld_i;
    assign flt_o = flt_i;
    assign dat_o = dat_i;
  end else begin : g_pipe
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] flt_q;
    logic [31:0]       dat_q [STAGES];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        flt_q <= '0;
        for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        flt_q[0] <= flt_i;
        dat_q[0] <= dat_i;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
          flt_q[i] <= flt_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign vld_o = vld_q[STAGES-1];
    assign flt_o = flt_q[STAGES-1];
    assign dat_o = dat_q[STAGES-1];
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined byte-addressed data RAM: stores commit at accept, loads respond after READ_LAT edges.
// No response backpressure; reqReady low during INIT (zero sweep when DMEM_ZERO_INIT_EN is defined).
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_pipe_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;

  logic [31:0]      mem_q [DEPTH_WORDS];

  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep_we;

  logic             accept;
  logic [2:0]       op;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             range_err;
  logic             req_flt;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_dat;

  logic             s1_vld_q, s1_vld_d;
  logic             s1_flt_q, s1_flt_d;
  logic [31:0]      s1_dat_q, s1_dat_d;

  assign op        = bus.memRW;
  assign off       = bus.addr[1:0];
  assign idx       = bus.addr[AW-1:2];
  assign range_err = |bus.addr[31:AW];
  assign req_flt   = range_err || misaligned(op, off);
  assign accept    = bus.reqValid && bus.reqReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMEM_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      DMEM_INIT: begin
`ifdef DMEM_ZERO_INIT_EN
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = DMEM_RUN;
`else
        state_d = DMEM_RUN;
`endif
      end
      DMEM_RUN: state_d = DMEM_RUN;
      default:  state_d = DMEM_INIT;
    endcase
  end

  assign bus.reqReady = (state_q == DMEM_RUN);
`ifdef DMEM_ZERO_INIT_EN
  assign bus.busy = (state_q == DMEM_INIT);
`else
  assign bus.busy = 1'b0;
`endif

  // Sweep and CPU stores share one write port; they never overlap since INIT holds reqReady low.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_mask = store_mask(op, off);
    wr_dat  = store_lanes(op, bus.dataW);
    if (sweep_we) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_mask = 4'hF;
      wr_dat  = '0;
    end else if (accept && is_store(op) && !req_flt) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem_q[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  // First response stage: registered, already-extended read; zero unless a clean load.
  always_comb begin
    s1_vld_d = accept;
    s1_flt_d = accept && req_flt;
    s1_dat_d = '0;
    if (accept && !req_flt && !is_store(op)) s1_dat_d = load_ext(op, off, mem_q[idx]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_flt_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_flt_q <= s1_flt_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  dmem_rsp_pipe #(
    .STAGES (READ_LAT - 1)
  ) u_rsp_pipe (
    .clk   (clk),
    .reset (reset),
    .vld_i (s1_vld_q),
    .flt_i (s1_flt_q),
    .dat_i (s1_dat_q),
    .vld_o (bus.rspValid),
    .flt_o (bus.fault),
    .dat_o (bus.dataR)
  );

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: one request stream drives a READ_LAT=3 and a READ_LAT=1 instance in parallel.
// Responses are captured per instance and checked in order with their measured latency.
module tb_dmem_pipe;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
`ifdef DMEM_ZERO_INIT_EN
  localparam int          INIT_CYC  = DEPTH;
  localparam logic        EXP_BUSY  = 1'b1;
  localparam logic [31:0] EXP_MEM20 = 32'h0000_0000;
`else
  localparam int          INIT_CYC  = 1;
  localparam logic        EXP_BUSY  = 1'b0;
  localparam logic [31:0] EXP_MEM20 = 32'h11AA_BEEF;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_pipe_if bus3 ();
  dmem_pipe_if bus1 ();

  assign bus1.reqValid = bus3.reqValid;
  assign bus1.memRW    = bus3.memRW;
  assign bus1.addr     = bus3.addr;
  assign bus1.dataW    = bus3.dataW;

  dmem_pipe #(.DEPTH_WORDS(DEPTH), .READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  dmem_pipe #(.DEPTH_WORDS(DEPTH), .READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct { logic [31:0] dat; logic flt; int lat; int cyc; } rsp_t;
  typedef struct { logic [31:0] dat; logic flt; } exp_t;

  rsp_t rsp3[$];
  rsp_t rsp1[$];
  exp_t expq[$];
  int   acc3[$];
  int   acc1[$];
  int   cyc = 0;
  int   checks = 0, passed = 0, fails = 0;
  int   f_cyc, l_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rsp_t mk_rsp(input logic [31:0] d, input logic f, input int lat, input int c);
    rsp_t r;
    r.dat = d; r.flt = f; r.lat = lat; r.cyc = c;
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      acc3.delete();
      acc1.delete();
    end else begin
      if (bus3.rspValid)
        rsp3.push_back(mk_rsp(bus3.dataR, bus3.fault, (acc3.size() > 0) ? cyc - acc3.pop_front() : -1, cyc));
      if (bus1.rspValid)
        rsp1.push_back(mk_rsp(bus1.dataR, bus1.fault, (acc1.size() > 0) ? cyc - acc1.pop_front() : -1, cyc));
      if (bus3.reqValid && bus3.reqReady) acc3.push_back(cyc);
      if (bus1.reqValid && bus1.reqReady) acc1.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ef);
    exp_t e;
    e.dat = ed; e.flt = ef;
    expq.push_back(e);
    bus3.reqValid = 1'b1;
    bus3.memRW    = op;
    bus3.addr     = a;
    bus3.dataW    = d;
    @(posedge clk); #1;
    bus3.reqValid = 1'b0;
  endtask

  task automatic drain(input string tag, output int first_c, output int last_c);
    int n, waited;
    n = expq.size();
    waited = 0;
    first_c = 0;
    last_c = 0;
    while ((rsp3.size() < n || rsp1.size() < n) && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("%s count lat3", tag), rsp3.size(), n);
    chk($sformatf("%s count lat1", tag), rsp1.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rsp3.size()) begin
        chk($sformatf("%s[%0d] dataR lat3", tag, i), rsp3[i].dat, expq[i].dat);
        chk1($sformatf("%s[%0d] fault lat3", tag, i), rsp3[i].flt, expq[i].flt);
        chk($sformatf("%s[%0d] latency lat3", tag, i), rsp3[i].lat, 3);
        if (i == 0) first_c = rsp3[i].cyc;
        last_c = rsp3[i].cyc;
      end
      if (i < rsp1.size()) begin
        chk($sformatf("%s[%0d] dataR lat1", tag, i), rsp1[i].dat, expq[i].dat);
        chk1($sformatf("%s[%0d] fault lat1", tag, i), rsp1[i].flt, expq[i].flt);
        chk($sformatf("%s[%0d] latency lat1", tag, i), rsp1[i].lat, 1);
      end
    end
    expq.delete();
    rsp3.delete();
    rsp1.delete();
    chk1($sformatf("%s idle rspValid", tag), bus3.rspValid, 1'b0);
    chk($sformatf("%s idle dataR", tag), bus3.dataR, 32'h0);
    chk1($sformatf("%s idle fault", tag), bus3.fault, 1'b0);
  endtask

  task automatic reset_vals(input string tag);
    chk1($sformatf("%s reqReady", tag), bus3.reqReady, 1'b0);
    chk1($sformatf("%s rspValid", tag), bus3.rspValid, 1'b0);
    chk($sformatf("%s dataR", tag), bus3.dataR, 32'h0);
    chk1($sformatf("%s fault", tag), bus3.fault, 1'b0);
    chk1($sformatf("%s busy", tag), bus3.busy, EXP_BUSY);
    chk1($sformatf("%s rspValid lat1", tag), bus1.rspValid, 1'b0);
    chk1($sformatf("%s reqReady lat1", tag), bus1.reqReady, 1'b0);
  endtask

  // Called right after reset deasserts (#1 past an edge).
  task automatic init_chk(input string tag);
    chk1($sformatf("%s init rdy", tag), bus3.reqReady, 1'b0);
    chk1($sformatf("%s init busy", tag), bus3.busy, EXP_BUSY);
    for (int i = 1; i < INIT_CYC; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("%s init rdy c%0d", tag, i), bus3.reqReady, 1'b0);
      chk1($sformatf("%s init busy c%0d", tag, i), bus3.busy, EXP_BUSY);
    end
    @(posedge clk); #1;
    chk1($sformatf("%s run rdy", tag), bus3.reqReady, 1'b1);
    chk1($sformatf("%s run busy", tag), bus3.busy, 1'b0);
    chk1($sformatf("%s run rdy lat1", tag), bus1.reqReady, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus3.reqValid = 1'b0;
    bus3.memRW    = MEM_LW;
    bus3.addr     = 32'h0;
    bus3.dataW    = 32'h0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("por");
    reset = 1'b0;
    init_chk("por");

`ifndef DMEM_ZERO_INIT_EN
    issue(MEM_SW, 32'h00, 32'h0, 32'h0, 1'b0);
    issue(MEM_SW, 32'hFC, 32'h0, 32'h0, 1'b0);
`endif
    issue(MEM_LW, 32'h00, 32'h0, 32'h0, 1'b0);
    issue(MEM_LW, 32'hFC, 32'h0, 32'h0, 1'b0);
    drain("init", f_cyc, l_cyc);

    issue(MEM_SW,  32'h10, 32'h80FF7F01, 32'h0,        1'b0);
    issue(MEM_LB,  32'h10, 32'h0,        32'hFFFFFF80, 1'b0);
    issue(MEM_LBU, 32'h10, 32'h0,        32'h00000080, 1'b0);
    issue(MEM_LH,  32'h12, 32'h0,        32'h00007F01, 1'b0);
    issue(MEM_LHU, 32'h10, 32'h0,        32'h000080FF, 1'b0);
    issue(MEM_LW,  32'h10, 32'h0,        32'h80FF7F01, 1'b0);
    issue(MEM_LB,  32'h11, 32'h0,        32'hFFFFFFFF, 1'b0);
    issue(MEM_LBU, 32'h13, 32'h0,        32'h00000001, 1'b0);
    issue(MEM_LH,  32'h10, 32'h0,        32'hFFFF80FF, 1'b0);
    drain("order", f_cyc, l_cyc);

    issue(MEM_SW, 32'h20, 32'h11223344, 32'h0,        1'b0);
    issue(MEM_SB, 32'h21, 32'h123456AA, 32'h0,        1'b0);
    issue(MEM_SH, 32'h22, 32'hCAFEBEEF, 32'h0,        1'b0);
    issue(MEM_LW, 32'h20, 32'h0,        32'h11AABEEF, 1'b0);
    drain("partial", f_cyc, l_cyc);

    issue(MEM_LH,  32'h13,  32'h0,        32'h0,        1'b1);
    issue(MEM_SW,  32'h22,  32'hFFFFFFFF, 32'h0,        1'b1);
    issue(MEM_LW,  32'h100, 32'h0,        32'h0,        1'b1);
    issue(MEM_SB,  32'h100, 32'h00000055, 32'h0,        1'b1);
    issue(MEM_SH,  32'h21,  32'h0000DDDD, 32'h0,        1'b1);
    issue(MEM_LHU, 32'h23,  32'h0,        32'h0,        1'b1);
    issue(MEM_LW,  32'h20,  32'h0,        32'h11AABEEF, 1'b0);
    issue(MEM_LW,  32'h00,  32'h0,        32'h00000000, 1'b0);
    drain("fault", f_cyc, l_cyc);

    issue(MEM_LW,  32'h10, 32'h0, 32'h80FF7F01, 1'b0);
    issue(MEM_LW,  32'h20, 32'h0, 32'h11AABEEF, 1'b0);
    issue(MEM_LBU, 32'h11, 32'h0, 32'h000000FF, 1'b0);
    issue(MEM_LB,  32'h12, 32'h0, 32'h0000007F, 1'b0);
    issue(MEM_LHU, 32'h22, 32'h0, 32'h0000BEEF, 1'b0);
    issue(MEM_LH,  32'h22, 32'h0, 32'hFFFFBEEF, 1'b0);
    issue(MEM_LB,  32'h21, 32'h0, 32'hFFFFFFAA, 1'b0);
    issue(MEM_LW,  32'hFC, 32'h0, 32'h00000000, 1'b0);
    drain("b2b", f_cyc, l_cyc);
    chk("b2b consecutive span", l_cyc - f_cyc, 7);

    bus3.reqValid = 1'b1;
    bus3.memRW    = MEM_LW;
    bus3.addr     = 32'h20;
    @(posedge clk); #1;
    bus3.addr     = 32'h10;
    @(posedge clk); #1;
    bus3.reqValid = 1'b0;
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midflight rsp lat3", rsp3.size(), 0);
    chk("midflight rsp lat1", rsp1.size(), 1);
    rsp1.delete();
    reset_vals("midflight");
    reset = 1'b0;
    init_chk("re-init");

    issue(MEM_LW, 32'h20, 32'h0, EXP_MEM20, 1'b0);
    issue(MEM_SW, 32'h30, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(MEM_LW, 32'h30, 32'h0, 32'hDEADBEEF, 1'b0);
    drain("after reset", f_cyc, l_cyc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
